gcd_job_sequencer: RTL and testbench
====================================

# gcd_job_sequencer

Upstream feeder for the GCD wrapper. Accepts operand pairs over a valid/ready port, buffers them in a small FIFO, and issues them one at a time to the GCD core using that core's `start`/`done` protocol. It captures each result `data_D` and presents it, with the operands that produced it, on a valid/ready result port. It lets a test harness or front end queue several GCD jobs without watching the core's handshake.

## Interface
Parameters:
- `WIDTH`, 4: operand and result width; matches the GCD core's data width.
- `DEPTH`, 4: job FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer offers a job.
- `in_ready`  out  1  FIFO not full.
- `in_A`  in  WIDTH  operand A of the offered job.
- `in_B`  in  WIDTH  operand B of the offered job.
- `data_A`  out  WIDTH  operand A to the GCD core.
- `data_B`  out  WIDTH  operand B to the GCD core.
- `start`  out  1  run request to the GCD core.
- `done`  in  1  GCD core completion flag.
- `data_D`  in  WIDTH  GCD core result.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_D`  out  WIDTH  gcd(res_A, res_B).
- `res_A`  out  WIDTH  operand A of the reported job.
- `res_B`  out  WIDTH  operand B of the reported job.
- `count`  out  log2(DEPTH)+1  current FIFO occupancy.

## Operation
- FIFO:
  - An enqueue occurs when `in_valid && in_ready`.
  - A dequeue occurs on the IDLE→ISSUE transition.
  - Both can happen in the same cycle; `count` is then unchanged.
  - Read and write pointers wrap modulo DEPTH.
- FSM states:
  - **IDLE**: `start`=0. If `count`>0 and `res_valid`=0, pop the head entry into the `data_A`/`data_B` registers and go to ISSUE.
  - **ISSUE**: `start`=1. Go to WAIT.
  - **WAIT**: `start`=1, `data_A`/`data_B` held stable.
    - `done` is sampled only in this state.
    - On the first cycle with `done`=1: latch `data_D` into `res_D`, copy the operands into `res_A`/`res_B`, set `res_valid`=1, go to DROP.
  - **DROP**: `start`=0 for exactly one cycle, so the core returns to idle. Go to IDLE.
- Result port:
  - `res_valid` clears on the cycle after `res_valid && res_ready`.
  - Outputs are held stable while `res_valid`=1 and `res_ready`=0.
  - No new job issues until the result slot is empty, so results never overwrite each other.
- `done` seen in IDLE, ISSUE or DROP is ignored.
- Operands are passed to the core unmodified; no arithmetic in this block.

## Timing
- Reset (synchronous): all outputs go to 0 — `data_A`, `data_B`, `start`, `res_valid`, `res_D`, `res_A`, `res_B`, `count`. Exception: `in_ready`=1. FSM goes to IDLE and FIFO pointers to 0.
- Reset asserted mid-job: `start` drops on the next edge, queued jobs and any pending result are discarded, and a later `done` is ignored.
- Enqueue to `start` high, with the core idle and the FIFO empty: 2 cycles (the enqueue edge, then IDLE→ISSUE).
- Capture of `done` to `res_valid`: 1 cycle.
- Gap between jobs: at least 2 cycles with `start`=0 (DROP plus IDLE).
- Full FIFO: `in_ready`=0 when `count`==DEPTH. An offer while full is not taken and the producer must hold it.
- Empty FIFO: the FSM stays in IDLE.

## Configuration
- `GCD_SEQ_ZERO_BYPASS_EN` defined:
  - In IDLE, a popped job with A==0 or B==0 skips the core entirely; `start` stays 0.
  - The result is written directly with `res_D` = A|B, so gcd(0,0)=0. `res_valid` rises on the cycle after the pop, and the FSM goes straight to DROP.
- Macro undefined: every job, including zero operands, goes through the core.

## Test plan
- Single job (15,5) enqueued after reset, behavioural core returning after 6 cycles → `start` high 2 cycles after the enqueue; `res_D`=5, `res_A`=15, `res_B`=5; `res_valid` for exactly one cycle with `res_ready`=1.
- Back-to-back jobs (12,4), (6,3), (15,5) → results 4, 3, 5 in order; `start` low for at least 2 cycles between jobs; `data_A`/`data_B` stable throughout every WAIT.
- Five jobs offered with DEPTH=4 and the core stalled → `in_ready`=0 after 4 accepts and `count`=4. The fifth job is accepted when the first pops, and all 5 results come out in order.
- `res_ready`=0 for 10 cycles after the first result → `res_*` held, no second `start` until the handshake completes.
- `reset` pulsed while in WAIT with 2 jobs queued → the next cycle shows `start`=0 and `count`=0; a late `done` produces no result.
- Job (0,9):
  - With the macro defined: `res_D`=9, no `start` pulse.
  - Without it: issued to the core normally.

Source files
------------

// File: rtl/gcd_job_sequencer_if.sv
// Port bundle for gcd_job_sequencer: job intake, GCD core handshake, result port and occupancy.
// The master modport is the sequencer's view; slave is the surrounding producer/core/consumer side.
interface gcd_job_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_A;
  logic [WIDTH-1:0]         in_B;
  logic [WIDTH-1:0]         data_A;
  logic [WIDTH-1:0]         data_B;
  logic                     start;
  logic                     done;
  logic [WIDTH-1:0]         data_D;
  logic                     res_valid;
  logic                     res_ready;
  logic [WIDTH-1:0]         res_D;
  logic [WIDTH-1:0]         res_A;
  logic [WIDTH-1:0]         res_B;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    input  in_valid, in_A, in_B, done, data_D, res_ready,
    output in_ready, data_A, data_B, start, res_valid, res_D, res_A, res_B, count
  );

  modport slave (
    output in_valid, in_A, in_B, done, data_D, res_ready,
    input  in_ready, data_A, data_B, start, res_valid, res_D, res_A, res_B, count
  );
endinterface

// File: rtl/gcd_job_sequencer.sv
// Queues GCD jobs in a small FIFO and runs them one at a time through the core's start/done handshake.
// Optional GCD_SEQ_ZERO_BYPASS_EN: jobs with a zero operand are answered locally (A|B) without the core.
module gcd_job_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  gcd_job_sequencer_if.master  bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] fifo_a [DEPTH];
  logic [WIDTH-1:0] fifo_b [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;

  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] res_d_q, res_a_q, res_b_q;
  logic             res_valid_q;

  logic             in_ready_c;
  logic             push, pop, capture, bypass_wr, res_take;
  logic             head_zero;
  logic             start_c;
  logic [WIDTH-1:0] head_a, head_b;

  assign head_a = fifo_a[rd_ptr];
  assign head_b = fifo_b[rd_ptr];

`ifdef GCD_SEQ_ZERO_BYPASS_EN
  assign head_zero = (head_a == '0) || (head_b == '0);
`else
  assign head_zero = 1'b0;
`endif

  assign in_ready_c = (count_q != FULL_CNT);
  assign push       = bus.in_valid && in_ready_c;
  // A new job only leaves the FIFO once the result slot is free, so results never collide.
  assign pop        = (state == IDLE) && (count_q != '0) && !res_valid_q;
  assign capture    = (state == WAIT) && bus.done;
  assign bypass_wr  = pop && head_zero;
  assign res_take   = res_valid_q && bus.res_ready;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = head_zero ? DROP : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus.done) state_nxt = DROP;
      DROP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    start_c = 1'b0;
    case (state)
      ISSUE, WAIT: start_c = 1'b1;
      default:     start_c = 1'b0;
    endcase
  end

  // Job FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= bus.in_A;
      fifo_b[wr_ptr] <= bus.in_B;
    end
  end

  // Operands presented to the core stay put from pop until the next pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a <= '0;
      op_b <= '0;
    end else if (pop) begin
      op_a <= head_a;
      op_b <= head_b;
    end
  end

  // Result slot
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_d_q     <= '0;
      res_a_q     <= '0;
      res_b_q     <= '0;
    end else if (capture) begin
      res_valid_q <= 1'b1;
      res_d_q     <= bus.data_D;
      res_a_q     <= op_a;
      res_b_q     <= op_b;
    end else if (bypass_wr) begin
      res_valid_q <= 1'b1;
      res_d_q     <= head_a | head_b;
      res_a_q     <= head_a;
      res_b_q     <= head_b;
    end else if (res_take) begin
      res_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.data_A    = op_a;
  assign bus.data_B    = op_b;
  assign bus.start     = start_c;
  assign bus.res_valid = res_valid_q;
  assign bus.res_D     = res_d_q;
  assign bus.res_A     = res_a_q;
  assign bus.res_B     = res_b_q;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Directed bench for gcd_job_sequencer with a behavioural GCD core (6-cycle latency, stallable).
module tb_gcd_job_sequencer;
  localparam int CORE_LAT = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gcd_job_sequencer_if #(.WIDTH(4), .DEPTH(4)) bus ();
  gcd_job_sequencer #(.WIDTH(4), .DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural core
  logic       core_done = 1'b0;
  logic [3:0] core_data = 4'd0;
  int         core_cnt  = 0;
  bit         core_stall = 1'b0;
  logic       force_done = 1'b0;

  function automatic logic [3:0] gcd_f(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] x, y, t;
    x = a; y = b;
    for (int i = 0; i < 16 && y != 4'd0; i++) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  always @(posedge clk) begin
    if (bus.start !== 1'b1) begin
      core_cnt  <= 0;
      core_done <= 1'b0;
    end else if (!core_stall && core_cnt >= CORE_LAT - 1) begin
      core_done <= 1'b1;
      core_data <= gcd_f(bus.data_A, bus.data_B);
    end else if (core_cnt < 20) begin
      core_cnt <= core_cnt + 1;
    end
  end

  assign bus.done   = core_done | force_done;
  assign bus.data_D = core_data;

  // Observation of results, start gaps and operand stability
  logic [11:0] res_q[$];
  int  start_rises = 0;
  int  low_run = 0;
  int  min_gap = 99;
  int  stab_err = 0;
  bit  seen_start = 1'b0;
  bit  start_prev = 1'b0;
  logic [3:0] hold_a, hold_b;

  always @(negedge clk) begin
    if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1)
      res_q.push_back({bus.res_D, bus.res_A, bus.res_B});
    if (bus.start === 1'b1) begin
      if (!start_prev) begin
        start_rises = start_rises + 1;
        if (seen_start && low_run < min_gap) min_gap = low_run;
        seen_start = 1'b1;
        hold_a = bus.data_A;
        hold_b = bus.data_B;
      end else if (bus.data_A !== hold_a || bus.data_B !== hold_b) begin
        stab_err = stab_err + 1;
      end
      low_run = 0;
      start_prev = 1'b1;
    end else begin
      low_run = low_run + 1;
      start_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_results(input int n, input int budget);
    for (int i = 0; i < budget && res_q.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_vec++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_vec++; if (bus.start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b want 0", bus.start); end
    n_vec++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
    n_vec++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_vec++; if ({bus.data_A, bus.data_B} !== 8'h00) begin n_bad++; $display("FAIL reset_data_AB: got %h want 00", {bus.data_A, bus.data_B}); end
    n_vec++; if ({bus.res_D, bus.res_A, bus.res_B} !== 12'h000) begin n_bad++; $display("FAIL reset_res_DAB: got %h want 000", {bus.res_D, bus.res_A, bus.res_B}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_job();
    bus.res_ready = 1'b1;
    bus.in_A = 4'd15; bus.in_B = 4'd5; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_vec++; if (bus.count !== 3'd1) begin n_bad++; $display("FAIL single_count_after_enq: got %0d want 1", bus.count); end
    n_vec++; if (bus.start !== 1'b0) begin n_bad++; $display("FAIL single_start_early: got %b want 0", bus.start); end
    tick();
    n_vec++; if (bus.start !== 1'b1) begin n_bad++; $display("FAIL single_start_latency: got %b want 1", bus.start); end
    n_vec++; if ({bus.data_A, bus.data_B} !== {4'd15, 4'd5}) begin n_bad++; $display("FAIL single_data_AB: got %h want f5", {bus.data_A, bus.data_B}); end
    for (int i = 0; i < 40 && bus.res_valid !== 1'b1; i++) tick();
    n_vec++; if (bus.res_valid !== 1'b1) begin n_bad++; $display("FAIL single_res_valid: got %b want 1", bus.res_valid); end
    n_vec++; if ({bus.res_D, bus.res_A, bus.res_B} !== {4'd5, 4'd15, 4'd5}) begin n_bad++; $display("FAIL single_result: got %h want 5f5", {bus.res_D, bus.res_A, bus.res_B}); end
    tick();
    n_vec++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL single_res_valid_one_cycle: got %b want 0", bus.res_valid); end
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ja [3] = '{4'd12, 4'd6, 4'd15};
    logic [3:0]  jb [3] = '{4'd4, 4'd3, 4'd5};
    logic [11:0] exp [3] = '{12'h4C4, 12'h363, 12'h5F5};
    bus.res_ready = 1'b1;
    res_q.delete();
    min_gap = 99; seen_start = 1'b0; stab_err = 0;
    for (int j = 0; j < 3; j++) begin
      bus.in_A = ja[j]; bus.in_B = jb[j]; bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    wait_results(3, 300);
    n_vec++; if (res_q.size() !== 3) begin n_bad++; $display("FAIL b2b_result_count: got %0d want 3", res_q.size()); end
    for (int j = 0; j < 3; j++) begin
      n_vec++; if (j >= res_q.size() || res_q[j] !== exp[j]) begin n_bad++; $display("FAIL b2b_result_%0d: got %h want %h", j, (j < res_q.size()) ? res_q[j] : 12'hxxx, exp[j]); end
    end
    n_vec++; if (min_gap < 2 || min_gap == 99) begin n_bad++; $display("FAIL b2b_start_gap: got %0d want >=2", min_gap); end
    n_vec++; if (stab_err !== 0) begin n_bad++; $display("FAIL b2b_operand_stability: got %0d changes want 0", stab_err); end
    repeat (4) tick();
  endtask

  task automatic test_full_fifo();
    logic [3:0]  ja [5] = '{4'd8, 4'd9, 4'd10, 4'd14, 4'd7};
    logic [3:0]  jb [5] = '{4'd12, 4'd6, 4'd15, 4'd7, 4'd5};
    logic [11:0] exp [6] = '{12'h393, 12'h48C, 12'h396, 12'h5AF, 12'h7E7, 12'h175};
    int acc;
    bit took;
    bus.res_ready = 1'b1;
    res_q.delete();
    core_stall = 1'b1;
    // Lead job sits in the stalled core so the four queued jobs cannot drain.
    bus.in_A = 4'd9; bus.in_B = 4'd3; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && bus.start !== 1'b1; i++) tick();
    acc = 0;
    for (int j = 0; j < 4; j++) begin
      bus.in_A = ja[j]; bus.in_B = jb[j]; bus.in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
        took = bus.in_ready;
        tick();
        if (took) begin acc++; break; end
      end
    end
    bus.in_A = ja[4]; bus.in_B = jb[4]; bus.in_valid = 1'b1;
    n_vec++; if (acc !== 4) begin n_bad++; $display("FAIL full_accepts: got %0d want 4", acc); end
    n_vec++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL full_count: got %0d want 4", bus.count); end
    n_vec++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
    repeat (5) tick();
    n_vec++; if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL full_held_offer: count %0d in_ready %b want 4/0", bus.count, bus.in_ready); end
    core_stall = 1'b0;
    took = 1'b0;
    for (int k = 0; k < 40 && !took; k++) begin
      took = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    n_vec++; if (took !== 1'b1) begin n_bad++; $display("FAIL full_fifth_accepted: got %b want 1", took); end
    n_vec++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL full_count_after_fifth: got %0d want 4", bus.count); end
    wait_results(6, 600);
    n_vec++; if (res_q.size() !== 6) begin n_bad++; $display("FAIL full_result_count: got %0d want 6", res_q.size()); end
    for (int j = 0; j < 6; j++) begin
      n_vec++; if (j >= res_q.size() || res_q[j] !== exp[j]) begin n_bad++; $display("FAIL full_result_%0d: got %h want %h", j, (j < res_q.size()) ? res_q[j] : 12'hxxx, exp[j]); end
    end
    repeat (4) tick();
  endtask

  task automatic test_res_backpressure();
    int rises_at;
    bus.res_ready = 1'b0;
    res_q.delete();
    bus.in_A = 4'd12; bus.in_B = 4'd8; bus.in_valid = 1'b1;
    tick();
    bus.in_A = 4'd15; bus.in_B = 4'd10;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 60 && bus.res_valid !== 1'b1; i++) tick();
    n_vec++; if ({bus.res_valid, bus.res_D, bus.res_A, bus.res_B} !== {1'b1, 4'd4, 4'd12, 4'd8}) begin n_bad++; $display("FAIL bp_first_result: got %b/%h want 1/4c8", bus.res_valid, {bus.res_D, bus.res_A, bus.res_B}); end
    rises_at = start_rises;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++; if (bus.res_valid !== 1'b1 || {bus.res_D, bus.res_A, bus.res_B} !== 12'h4C8 || bus.start !== 1'b0) begin n_bad++; $display("FAIL bp_hold_cycle%0d: valid %b res %h start %b want 1/4c8/0", i, bus.res_valid, {bus.res_D, bus.res_A, bus.res_B}, bus.start); end
    end
    n_vec++; if (start_rises !== rises_at || bus.count !== 3'd1) begin n_bad++; $display("FAIL bp_no_issue: extra starts %0d count %0d want 0/1", start_rises - rises_at, bus.count); end
    bus.res_ready = 1'b1;
    tick();
    n_vec++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL bp_clear_after_handshake: got %b want 0", bus.res_valid); end
    wait_results(2, 100);
    n_vec++; if (res_q.size() !== 2 || res_q[1] !== 12'h5FA) begin n_bad++; $display("FAIL bp_second_result: size %0d got %h want 5fa", res_q.size(), (res_q.size() > 1) ? res_q[1] : 12'hxxx); end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_job();
    bus.res_ready = 1'b1;
    core_stall = 1'b1;
    bus.in_A = 4'd6; bus.in_B = 4'd4; bus.in_valid = 1'b1;
    tick();
    bus.in_A = 4'd9; bus.in_B = 4'd3;
    tick();
    bus.in_A = 4'd8; bus.in_B = 4'd4;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && !(bus.start === 1'b1 && bus.count === 3'd2); i++) tick();
    n_vec++; if (bus.start !== 1'b1 || bus.count !== 3'd2) begin n_bad++; $display("FAIL midrst_setup: start %b count %0d want 1/2", bus.start, bus.count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (bus.start !== 1'b0) begin n_bad++; $display("FAIL midrst_start: got %b want 0", bus.start); end
    n_vec++; if (bus.count !== 3'd0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_fifo: count %0d in_ready %b want 0/1", bus.count, bus.in_ready); end
    core_stall = 1'b0;
    res_q.delete();
    force_done = 1'b1;
    repeat (3) tick();
    force_done = 1'b0;
    repeat (5) tick();
    n_vec++; if (res_q.size() !== 0 || bus.res_valid !== 1'b0 || bus.start !== 1'b0) begin n_bad++; $display("FAIL midrst_late_done: results %0d valid %b start %b want 0/0/0", res_q.size(), bus.res_valid, bus.start); end
  endtask

  task automatic test_zero_job();
    int r0;
    bus.res_ready = 1'b1;
    res_q.delete();
    r0 = start_rises;
    bus.in_A = 4'd0; bus.in_B = 4'd9; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
`ifdef GCD_SEQ_ZERO_BYPASS_EN
    n_vec++; if (bus.res_valid !== 1'b1 || bus.start !== 1'b0) begin n_bad++; $display("FAIL zero_bypass_timing: valid %b start %b want 1/0", bus.res_valid, bus.start); end
`endif
    wait_results(1, 60);
    n_vec++; if (res_q.size() !== 1 || res_q[0] !== 12'h909) begin n_bad++; $display("FAIL zero_result_0_9: size %0d got %h want 909", res_q.size(), (res_q.size() > 0) ? res_q[0] : 12'hxxx); end
    repeat (3) tick();
    bus.in_A = 4'd0; bus.in_B = 4'd0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_results(2, 60);
    n_vec++; if (res_q.size() !== 2 || res_q[1] !== 12'h000) begin n_bad++; $display("FAIL zero_result_0_0: size %0d got %h want 000", res_q.size(), (res_q.size() > 1) ? res_q[1] : 12'hxxx); end
`ifdef GCD_SEQ_ZERO_BYPASS_EN
    n_vec++; if (start_rises - r0 !== 0) begin n_bad++; $display("FAIL zero_start_pulses: got %0d want 0", start_rises - r0); end
`else
    n_vec++; if (start_rises - r0 !== 2) begin n_bad++; $display("FAIL zero_start_pulses: got %0d want 2", start_rises - r0); end
`endif
    repeat (4) tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_A = 4'd0; bus.in_B = 4'd0; bus.res_ready = 1'b1;
    test_reset();
    test_single_job();
    test_back_to_back();
    test_full_fifo();
    test_res_backpressure();
    test_reset_mid_job();
    test_zero_job();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time budget exhausted, got running want finished");
    $fatal(1, "watchdog expired");
  end
endmodule
